// File: rtl/fee_calc_arbiter.sv
// Round-robin arbiter sharing one fee calculator between N_GATES exit gates, one transaction in flight.
// Optional WAIT-state timeout is built only when FEE_ARB_TIMEOUT_EN is defined.
module fee_calc_arbiter #(
    parameter int N_GATES        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_GATES-1:0]     gate_req,
    input  logic [32*N_GATES-1:0]  gate_entry_time,
    input  logic [32*N_GATES-1:0]  gate_exit_time,
    input  logic [8*N_GATES-1:0]   gate_vehicle_id,
    output logic [N_GATES-1:0]     gate_ack,
    output logic [N_GATES-1:0]     gate_done,
    output logic [7:0]             gate_fee,
    output logic                   gate_err,
    output logic                   busy,
    output logic [31:0]            calc_entry_time,
    output logic [31:0]            calc_exit_time,
    output logic [7:0]             calc_vehicle_id,
    output logic                   calc_start,
    input  logic [7:0]             calc_fee_amount,
    input  logic                   calc_fee_valid
);

    localparam int PW = (N_GATES > 1) ? $clog2(N_GATES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

    state_t               r_state, w_next_state;
    logic [PW-1:0]        r_rr_ptr;
    logic [N_GATES-1:0]   r_gate_ack, r_gate_done;
    logic [7:0]           r_gate_fee;
    logic                 r_gate_err, r_busy, r_calc_start, r_timed_out;
    logic [31:0]          r_calc_entry, r_calc_exit;
    logic [7:0]           r_calc_id;
    logic                 w_any_req, w_timeout;
    logic [PW-1:0]        w_winner;

    // First requester strictly after the last winner, wrapping modulo N_GATES.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_any_req = 1'b0;
        w_winner  = r_rr_ptr;
        for (int i = 1; i <= N_GATES; i++) begin
            if (!w_any_req && gate_req[(int'(r_rr_ptr) + i) % N_GATES]) begin
                w_any_req = 1'b1;
                w_winner  = PW'((int'(r_rr_ptr) + i) % N_GATES);
            end
        end
    end

`ifdef FEE_ARB_TIMEOUT_EN
    logic [15:0] r_wait_cnt;

    // Counter sits at zero outside WAIT, so it restarts on every WAIT entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_wait_cnt <= '0;
        else if (r_state != S_WAIT)
            r_wait_cnt <= '0;
        else
            r_wait_cnt <= r_wait_cnt + 16'd1;
    end

    assign w_timeout = (r_state == S_WAIT) && !calc_fee_valid &&
                       (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    // Without the counter a timeout can never fire.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:    if (w_any_req) w_next_state = S_ISSUE;
            S_ISSUE:   w_next_state = S_WAIT;
            S_WAIT:    if (calc_fee_valid || w_timeout) w_next_state = S_RESPOND;
            S_RESPOND: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr     <= PW'(N_GATES - 1);
            r_gate_ack   <= '0;
            r_gate_done  <= '0;
            r_gate_fee   <= '0;
            r_gate_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_calc_start <= 1'b0;
            r_timed_out  <= 1'b0;
            r_calc_entry <= '0;
            r_calc_exit  <= '0;
            r_calc_id    <= '0;
        end else begin
            // NOTE: pulse outputs default low each cycle; only the owning state raises them.
            r_gate_ack   <= '0;
            r_gate_done  <= '0;
            r_gate_err   <= 1'b0;
            r_calc_start <= 1'b0;
            r_busy       <= (w_next_state != S_IDLE);
            unique case (r_state)
                S_IDLE: if (w_any_req) begin
                    r_calc_entry         <= gate_entry_time[int'(w_winner)*32 +: 32];
                    r_calc_exit          <= gate_exit_time[int'(w_winner)*32 +: 32];
                    r_calc_id            <= gate_vehicle_id[int'(w_winner)*8 +: 8];
                    r_rr_ptr             <= w_winner;
                    r_gate_ack[w_winner] <= 1'b1;
                    r_calc_start         <= 1'b1;
                    r_timed_out          <= 1'b0;
                end
                S_WAIT: begin
                    if (calc_fee_valid) begin
                        r_gate_fee <= calc_fee_amount;
                    end else if (w_timeout) begin
                        r_gate_fee  <= 8'hFF;
                        r_timed_out <= 1'b1;
                    end
                end
                S_RESPOND: begin
                    r_gate_done[r_rr_ptr] <= 1'b1;
                    r_gate_err            <= r_timed_out;
                end
                default: ;
            endcase
        end
    end

    assign gate_ack        = r_gate_ack;
    assign gate_done       = r_gate_done;
    assign gate_fee        = r_gate_fee;
    assign gate_err        = r_gate_err;
    assign busy            = r_busy;
    assign calc_entry_time = r_calc_entry;
    assign calc_exit_time  = r_calc_exit;
    assign calc_vehicle_id = r_calc_id;
    assign calc_start      = r_calc_start;

endmodule

// File: tb/tb_fee_calc_arbiter.sv
// Directed bench for fee_calc_arbiter: table of single transactions plus hand-written
// sequences for stray strobes, reset during WAIT and (with FEE_ARB_TIMEOUT_EN) timeout.
module tb_fee_calc_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int NV = 11;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    gate_req;
    logic [32*N-1:0] gate_entry_time, gate_exit_time;
    logic [8*N-1:0]  gate_vehicle_id;
    logic [N-1:0]    gate_ack, gate_done;
    logic [7:0]      gate_fee;
    logic            gate_err, busy, calc_start;
    logic [31:0]     calc_entry_time, calc_exit_time;
    logic [7:0]      calc_vehicle_id, calc_fee_amount;
    logic            calc_fee_valid;

    always #5 clk = ~clk;

    fee_calc_arbiter #(.N_GATES(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .gate_req(gate_req),
        .gate_entry_time(gate_entry_time), .gate_exit_time(gate_exit_time),
        .gate_vehicle_id(gate_vehicle_id), .gate_ack(gate_ack), .gate_done(gate_done),
        .gate_fee(gate_fee), .gate_err(gate_err), .busy(busy),
        .calc_entry_time(calc_entry_time), .calc_exit_time(calc_exit_time),
        .calc_vehicle_id(calc_vehicle_id), .calc_start(calc_start),
        .calc_fee_amount(calc_fee_amount), .calc_fee_valid(calc_fee_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_grant = 0;

    always @(negedge clk) begin
        if (calc_start) n_start++;
        if (|gate_ack)  n_grant++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        int           gate;
        logic [31:0]  entry;
        logic [31:0]  exit_t;
        logic [7:0]   id;
        logic [7:0]   fee;
        int           delay;
        bit           hold;
        bit           stray;
    } vec_t;

    vec_t vecs [NV];

    function automatic logic [31:0] def_entry(input int g); return 32'(1000 + 16*g); endfunction
    function automatic logic [31:0] def_exit(input int g);  return 32'(2000 + 16*g); endfunction
    function automatic logic [7:0]  def_id(input int g);    return 8'(8'h40 + g);    endfunction

    function automatic vec_t mk(input logic [N-1:0] req, input int gate, input logic [7:0] fee,
                                input int delay, input bit hold, input bit stray);
        vec_t v;
        v.req = req; v.gate = gate; v.fee = fee; v.delay = delay; v.hold = hold; v.stray = stray;
        v.entry = def_entry(gate); v.exit_t = def_exit(gate); v.id = def_id(gate);
        return v;
    endfunction

    task automatic drive_data(input vec_t v);
        for (int g = 0; g < N; g++) begin
            gate_entry_time[32*g +: 32] = def_entry(g);
            gate_exit_time[32*g +: 32]  = def_exit(g);
            gate_vehicle_id[8*g +: 8]   = def_id(g);
        end
        gate_entry_time[32*v.gate +: 32] = v.entry;
        gate_exit_time[32*v.gate +: 32]  = v.exit_t;
        gate_vehicle_id[8*v.gate +: 8]   = v.id;
    endtask

    // Returns with the current time at the negedge on which gate_ack is visible.
    task automatic wait_ack(input string tag, output bit got);
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (|gate_ack) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s ack: no ack within 8 cycles, got 0x%0h", tag, gate_ack);
        end
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        bit got;
        gate_req = v.req;
        drive_data(v);
        wait_ack(tag, got);
        if (!got) return;
        check({tag, " ack"}, 64'(gate_ack), 64'(1 << v.gate));
        check({tag, " start"}, 64'(calc_start), 64'd1);
        check({tag, " busy_issue"}, 64'(busy), 64'd1);
        check({tag, " cap_entry"}, 64'(calc_entry_time), 64'(v.entry));
        check({tag, " cap_exit"}, 64'(calc_exit_time), 64'(v.exit_t));
        check({tag, " cap_id"}, 64'(calc_vehicle_id), 64'(v.id));
        if (!v.hold) begin
            gate_req        = '0;
            gate_entry_time = ~gate_entry_time;
            gate_exit_time  = ~gate_exit_time;
            gate_vehicle_id = ~gate_vehicle_id;
        end
        if (v.stray) begin
            calc_fee_valid  = 1'b1;
            calc_fee_amount = 8'h77;
        end
        for (int k = 1; k <= v.delay; k++) begin
            @(negedge clk);
            calc_fee_valid = 1'b0;
            check({tag, " start_once"}, 64'(calc_start), 64'd0);
            check({tag, " no_early_done"}, 64'(gate_done), 64'd0);
            check({tag, " hold_calc"}, {calc_entry_time, calc_exit_time[23:0], calc_vehicle_id},
                  {v.entry, v.exit_t[23:0], v.id});
        end
        calc_fee_valid  = 1'b1;
        calc_fee_amount = v.fee;
        @(negedge clk);
        calc_fee_valid  = 1'b0;
        calc_fee_amount = 8'h5A;
        check({tag, " done_lat1"}, 64'(gate_done), 64'd0);
        check({tag, " busy_respond"}, 64'(busy), 64'd1);
        @(negedge clk);
        check({tag, " done"}, 64'(gate_done), 64'(1 << v.gate));
        check({tag, " fee"}, 64'(gate_fee), 64'(v.fee));
        check({tag, " err"}, 64'(gate_err), 64'd0);
        check({tag, " busy_idle"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(gate_done), 64'd0);
        check({tag, " fee_held"}, 64'(gate_fee), 64'(v.fee));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " zero_a"}, {gate_ack, gate_done, gate_fee, gate_err, busy, calc_start,
                                 calc_vehicle_id}, 64'd0);
        check({tag, " zero_b"}, {calc_entry_time, calc_exit_time}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        bit   got;
        vec_t v;
        int   hit;
        int   exp_txn;

        // Round robin with all four held high, then assorted masks continuing the pointer.
        vecs[0]  = mk(4'b1111, 0, 8'd10,  1, 1, 0);
        vecs[1]  = mk(4'b1111, 1, 8'd20,  2, 1, 0);
        vecs[2]  = mk(4'b1111, 2, 8'd30,  3, 1, 0);
        vecs[3]  = mk(4'b1111, 3, 8'd40,  1, 1, 0);
        vecs[4]  = mk(4'b1111, 0, 8'd50,  2, 0, 0);
        vecs[5]  = mk(4'b0100, 2, 8'd25,  4, 0, 0);
        vecs[5].entry = 32'd100; vecs[5].exit_t = 32'd190; vecs[5].id = 8'd7;
        vecs[6]  = mk(4'b1011, 3, 8'h00,  2, 0, 0);
        vecs[7]  = mk(4'b0011, 0, 8'hFF,  5, 0, 1);
        vecs[8]  = mk(4'b0110, 1, 8'h80,  1, 0, 0);
        vecs[9]  = mk(4'b1000, 3, 8'd3,   3, 0, 0);
        vecs[10] = mk(4'b0001, 0, 8'd1,   2, 0, 0);

        reset_n = 1'b0; gate_req = '0; calc_fee_valid = 1'b0; calc_fee_amount = '0;
        gate_entry_time = '0; gate_exit_time = '0; gate_vehicle_id = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset_idle");

        for (int i = 0; i < NV; i++) run_txn($sformatf("v%0d", i), vecs[i]);

        // Stray strobe while idle: nothing happens, previous fee stays.
        gate_req = '0;
        calc_fee_valid = 1'b1; calc_fee_amount = 8'h55;
        @(negedge clk);
        calc_fee_valid = 1'b0;
        check("stray_idle busy", 64'(busy), 64'd0);
        check("stray_idle ack", 64'(gate_ack), 64'd0);
        @(negedge clk);
        check("stray_idle done", 64'(gate_done), 64'd0);
        check("stray_idle fee", 64'(gate_fee), 64'd1);

        // Reset in the middle of WAIT: outputs clear at once, no done, pointer back to N-1.
        v = mk(4'b0001, 0, 8'd0, 1, 0, 0);
        gate_req = v.req;
        drive_data(v);
        wait_ack("rst_mid", got);
        check("rst_mid ack", 64'(gate_ack), 64'b0001);
        gate_req = '0;
        repeat (2) @(negedge clk);
        check("rst_mid busy_wait", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check_zero("rst_mid async");
        @(negedge clk);
        reset_n = 1'b1;
        calc_fee_valid = 1'b1; calc_fee_amount = 8'h33;
        @(negedge clk);
        calc_fee_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_mid no_done", {gate_done, gate_err, busy}, 64'd0);
        end
        run_txn("rst_after", mk(4'b0011, 0, 8'd99, 2, 0, 0));
        exp_txn = NV + 2;

`ifdef FEE_ARB_TIMEOUT_EN
        // Calculator never answers: done+err with fee FF, late strobe ignored.
        v = mk(4'b0100, 2, 8'd0, 1, 0, 0);
        gate_req = v.req;
        drive_data(v);
        wait_ack("tmo", got);
        check("tmo ack", 64'(gate_ack), 64'b0100);
        gate_req = '0;
        hit = -1;
        for (int k = 1; k <= TO + 4; k++) begin
            @(negedge clk);
            if (hit < 0 && |gate_done) begin
                hit = k;
                check("tmo done", 64'(gate_done), 64'b0100);
                check("tmo err", 64'(gate_err), 64'd1);
                check("tmo fee", 64'(gate_fee), 64'hFF);
            end
        end
        check("tmo latency", 64'(hit), 64'(TO + 2));
        calc_fee_valid = 1'b1; calc_fee_amount = 8'h11;
        @(negedge clk);
        calc_fee_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("tmo late_valid", {gate_done, gate_err, busy, gate_fee}, 64'hFF);
        end
        exp_txn = exp_txn + 1;
`endif

        check("start_count", 64'(n_start), 64'(exp_txn));
        check("grant_count", 64'(n_grant), 64'(exp_txn));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
